// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, counter type and RGB444 pixel type.
// Shared by the display timing generator and its delay line.
package vga_timing_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FRONT    = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BACK     = 48;
    localparam int V_ACTIVE   = 480;
    localparam int V_FRONT    = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BACK     = 33;
    localparam int PIPE_DELAY = 2;

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int HS_STOP  = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FRONT;
    localparam int VS_STOP  = VS_START + V_SYNC;

    typedef logic [9:0] cnt_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/vga_display_timing_if.sv
// Display-side bundle: composer strobes, palette colour and VGA pins.
// master = timing generator, slave = composer/board side.
interface vga_display_timing_if;

    logic        video_enable;
    logic        display_next_pixel;
    logic        display_next_line;
    logic        display_next_frame;
    logic        display_current_field;
    logic [11:0] rgb_in;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;

    modport master (
        input  video_enable,
        input  rgb_in,
        output display_next_pixel,
        output display_next_line,
        output display_next_frame,
        output display_current_field,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hsync,
        output vga_vsync
    );

    modport slave (
        output video_enable,
        output rgb_in,
        input  display_next_pixel,
        input  display_next_line,
        input  display_next_frame,
        input  display_current_field,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hsync,
        input  vga_vsync
    );

endinterface

// File: rtl/sync_delay_line.sv
// WIDTH x DEPTH shift register with synchronous active-low clear.
// Cleared stages read as zero.
module sync_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_display_timing.sv
// Raster timing generator with sync-aligned RGB444 output registers.
// Define VGA_DISPLAY_TIMING_FIELD_EN to toggle the field flag per frame.
module vga_display_timing #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BACK     = vga_timing_pkg::H_BACK,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BACK     = vga_timing_pkg::V_BACK,
    parameter int PIPE_DELAY = vga_timing_pkg::PIPE_DELAY
) (
    input  logic                        clk,
    input  logic                        rst_n,
    vga_display_timing_if.master        disp_if
);

    import vga_timing_pkg::*;

    localparam cnt_t H_VIS  = cnt_t'(H_ACTIVE);
    localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FRONT);
    localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam cnt_t V_VIS  = cnt_t'(V_ACTIVE);
    localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FRONT);
    localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);

    logic    run_q, run_d;
    cnt_t    h_q, h_d;
    cnt_t    v_q, v_d;
    logic    pix_q, pix_d;
    logic    line_q, line_d;
    logic    frame_q, frame_d;
    logic    vis_raw, hs_raw, vs_raw;
    logic    vis_dl, hs_dl, vs_dl;
    rgb444_t rgb_q, rgb_d;
    logic    hs_n_q, hs_n_d;
    logic    vs_n_q, vs_n_d;

    // The counters hold the position of the current clock; strobes are
    // computed from the position being loaded so they line up with it.
    // run_q marks the first enabled clock, which shows (0,0) unadvanced.
    always_comb begin
        run_d = 1'b0;
        h_d   = '0;
        v_d   = '0;
        if (disp_if.video_enable) begin
            run_d = 1'b1;
            if (run_q) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
                end else begin
                    h_d = h_q + cnt_t'(1);
                    v_d = v_q;
                end
            end
        end
        pix_d   = run_d && (h_d < H_VIS);
        line_d  = run_d && (h_d == H_LAST);
        frame_d = line_d && (v_d == V_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            pix_q   <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            h_q     <= h_d;
            v_q     <= v_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    // Visibility is carried active-high so a cleared stage means blank.
    assign vis_raw = run_q && (h_q < H_VIS) && (v_q < V_VIS);
    assign hs_raw  = run_q && (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_raw  = run_q && (v_q >= VS_BEG) && (v_q < VS_END);

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({vis_raw, hs_raw, vs_raw}),
        .q_o   ({vis_dl, hs_dl, vs_dl})
    );

    always_comb begin
        rgb_d  = vis_dl ? rgb444_t'(disp_if.rgb_in) : '0;
        hs_n_d = !hs_dl;
        vs_n_d = !vs_dl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q  <= '0;
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
        end else begin
            rgb_q  <= rgb_d;
            hs_n_q <= hs_n_d;
            vs_n_q <= vs_n_d;
        end
    end

`ifdef VGA_DISPLAY_TIMING_FIELD_EN
    logic field_q, field_d;

    assign field_d = frame_q ? !field_q : field_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            field_q <= 1'b0;
        end else begin
            field_q <= field_d;
        end
    end

    assign disp_if.display_current_field = field_q;
`else
    assign disp_if.display_current_field = 1'b0;
`endif

    assign disp_if.display_next_pixel = pix_q;
    assign disp_if.display_next_line  = line_q;
    assign disp_if.display_next_frame = frame_q;
    assign disp_if.vga_r              = rgb_q.r;
    assign disp_if.vga_g              = rgb_q.g;
    assign disp_if.vga_b              = rgb_q.b;
    assign disp_if.vga_hsync          = hs_n_q;
    assign disp_if.vga_vsync          = vs_n_q;

endmodule

// File: tb/tb_vga_display_timing.sv
// Bench for vga_display_timing: a reduced raster for frame-level work
// plus a default-size instance checked over its first line.
module tb_vga_display_timing;

    import vga_timing_pkg::*;

    localparam int HA  = 64;
    localparam int HF  = 8;
    localparam int HSY = 12;
    localparam int HB  = 6;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VA  = 20;
    localparam int VF  = 3;
    localparam int VSY = 2;
    localparam int VB  = 4;
    localparam int VT  = VA + VF + VSY + VB;
    localparam int FT  = HT * VT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;

    logic [13:0] sb_q [$];

    vga_display_timing_if dif ();
    vga_display_timing_if dif0 ();

    assign dif0.video_enable = dif.video_enable;
    assign dif0.rgb_in       = 12'hF0A;

    vga_display_timing #(
        .H_ACTIVE   (HA),
        .H_FRONT    (HF),
        .H_SYNC     (HSY),
        .H_BACK     (HB),
        .V_ACTIVE   (VA),
        .V_FRONT    (VF),
        .V_SYNC     (VSY),
        .V_BACK     (VB),
        .PIPE_DELAY (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp_if (dif)
    );

    vga_display_timing dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp_if (dif0)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    // Expected {rgb, hsync_n, vsync_n} of the reduced raster at position p.
    function automatic logic [13:0] exp_pins(int p, logic [11:0] rgb);
        int   h;
        int   v;
        logic vis;
        logic hsn;
        logic vsn;
        h   = p % HT;
        v   = (p / HT) % VT;
        vis = (h < HA) && (v < VA);
        hsn = !((h >= HA + HF) && (h < HA + HF + HSY));
        vsn = !((v >= VA + VF) && (v < VA + VF + VSY));
        return {vis ? rgb : 12'h000, hsn, vsn};
    endfunction

    function automatic logic exp_field(int p);
`ifdef VGA_DISPLAY_TIMING_FIELD_EN
        return ((p / FT) % 2) == 1;
`else
        return 1'b0 | (p < 0);
`endif
    endfunction

    task automatic test_reset();
        logic [17:0] got;
        rst_n = 1'b0;
        dif.video_enable = 1'b0;
        dif.rgb_in = 12'hF0A;
        repeat (3) @(negedge clk);
        got = {dif.display_next_pixel, dif.display_next_line,
               dif.display_next_frame, dif.display_current_field,
               dif.vga_r, dif.vga_g, dif.vga_b,
               dif.vga_hsync, dif.vga_vsync};
        n_cmp++;
        if (got !== {4'b0000, 12'h000, 2'b11}) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", got,
                     {4'b0000, 12'h000, 2'b11});
        end
        got = {dif0.display_next_pixel, dif0.display_next_line,
               dif0.display_next_frame, dif0.display_current_field,
               dif0.vga_r, dif0.vga_g, dif0.vga_b,
               dif0.vga_hsync, dif0.vga_vsync};
        n_cmp++;
        if (got !== {4'b0000, 12'h000, 2'b11}) begin
            n_bad++;
            $display("FAIL reset_state_full: got %h want %h", got,
                     {4'b0000, 12'h000, 2'b11});
        end
    endtask

    task automatic test_line();
        logic [2:0]  st;
        logic [2:0]  st_e;
        logic [13:0] pin;
        logic [13:0] pin_e;
        int          p;
        int          hs_low;
        hs_low = 0;
        rst_n = 1'b1;
        dif.video_enable = 1'b1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            k = c;
            st   = {dif.display_next_pixel, dif.display_next_line,
                    dif.display_next_frame};
            st_e = {(c % HT) < HA, (c % HT) == HT - 1, 1'b0};
            n_cmp++;
            if (st !== st_e) begin
                n_bad++;
                $display("FAIL line_strobes c=%0d: got %b want %b",
                         c, st, st_e);
            end
            st   = {dif0.display_next_pixel, dif0.display_next_line,
                    dif0.display_next_frame};
            st_e = {c < H_ACTIVE, c == H_TOTAL - 1, 1'b0};
            n_cmp++;
            if (st !== st_e) begin
                n_bad++;
                $display("FAIL full_line_strobes c=%0d: got %b want %b",
                         c, st, st_e);
            end
            p     = c - 3;
            pin   = {dif0.vga_r, dif0.vga_g, dif0.vga_b,
                     dif0.vga_hsync, dif0.vga_vsync};
            pin_e = {(p >= 0 && p < H_ACTIVE) ? 12'hF0A : 12'h000,
                     !(p >= HS_START && p < HS_STOP), 1'b1};
            n_cmp++;
            if (pin !== pin_e) begin
                n_bad++;
                $display("FAIL full_line_pins c=%0d: got %h want %h",
                         c, pin, pin_e);
            end
            if (dif0.vga_hsync === 1'b0) hs_low++;
        end
        n_cmp++;
        if (hs_low !== H_SYNC) begin
            n_bad++;
            $display("FAIL hsync_width: got %0d want %0d", hs_low, H_SYNC);
        end
    endtask

    task automatic test_frame();
        logic [3:0] st;
        logic [3:0] st_e;
        int         lines;
        int         frames;
        lines  = 0;
        frames = 0;
        while (k < 3 * FT + 2) begin
            tick();
            st   = {dif.display_next_pixel, dif.display_next_line,
                    dif.display_next_frame, dif.display_current_field};
            st_e = {(k % HT) < HA, (k % HT) == HT - 1,
                    (k % FT) == FT - 1, exp_field(k)};
            n_cmp++;
            if (st !== st_e) begin
                n_bad++;
                $display("FAIL frame_strobes k=%0d: got %b want %b",
                         k, st, st_e);
            end
            if (dif.display_next_line === 1'b1) lines++;
            if (dif.display_next_frame === 1'b1) begin
                frames++;
                if (frames > 1) begin
                    n_cmp++;
                    if (lines !== VT) begin
                        n_bad++;
                        $display("FAIL lines_per_frame: got %0d want %0d",
                                 lines, VT);
                    end
                end
                lines = 0;
            end
        end
        n_cmp++;
        if (frames !== 3) begin
            n_bad++;
            $display("FAIL frame_count: got %0d want 3", frames);
        end
    endtask

    task automatic test_colour();
        logic [11:0] rgb;
        logic [13:0] pin;
        logic [13:0] pin_e;
        for (int i = 0; i < FT + 10; i++) begin
            tick();
            if (sb_q.size() > 0) begin
                pin   = {dif.vga_r, dif.vga_g, dif.vga_b,
                         dif.vga_hsync, dif.vga_vsync};
                pin_e = sb_q.pop_front();
                n_cmp++;
                if (pin !== pin_e) begin
                    n_bad++;
                    $display("FAIL colour_pins k=%0d: got %h want %h",
                             k, pin, pin_e);
                end
            end
            rgb = 12'($urandom_range(1, 4095));
            dif.rgb_in = rgb;
            sb_q.push_back(exp_pins(k - 2, rgb));
        end
        tick();
        pin   = {dif.vga_r, dif.vga_g, dif.vga_b,
                 dif.vga_hsync, dif.vga_vsync};
        pin_e = sb_q.pop_front();
        n_cmp++;
        if (pin !== pin_e) begin
            n_bad++;
            $display("FAIL colour_pins_last: got %h want %h", pin, pin_e);
        end
        dif.rgb_in = 12'hF0A;
    endtask

    task automatic test_enable();
        logic        found;
        logic [2:0]  st;
        logic [13:0] pin;
        logic [13:0] pin_e;
        found = 1'b0;
        for (int i = 0; i < 2 * FT && !found; i++) begin
            tick();
            if ((k % HT) == 30 && ((k / HT) % VT) == 10) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL enable_wait: got timeout want position (30,10)");
        end
        dif.video_enable = 1'b0;
        for (int d = 0; d < 50; d++) begin
            @(negedge clk);
            st = {dif.display_next_pixel, dif.display_next_line,
                  dif.display_next_frame};
            n_cmp++;
            if (st !== 3'b000) begin
                n_bad++;
                $display("FAIL disabled_strobes d=%0d: got %b want 000",
                         d, st);
            end
            pin = {dif.vga_r, dif.vga_g, dif.vga_b,
                   dif.vga_hsync, dif.vga_vsync};
            pin_e = (d < 3) ? {12'hF0A, 2'b11} : {12'h000, 2'b11};
            n_cmp++;
            if (pin !== pin_e) begin
                n_bad++;
                $display("FAIL disabled_pins d=%0d: got %h want %h",
                         d, pin, pin_e);
            end
        end
        dif.video_enable = 1'b1;
        for (int c = 0; c < HT + 5; c++) begin
            @(negedge clk);
            k  = c;
            st = {dif.display_next_pixel, dif.display_next_line,
                  dif.display_next_frame};
            n_cmp++;
            if (st !== {(c % HT) < HA, (c % HT) == HT - 1, 1'b0}) begin
                n_bad++;
                $display("FAIL reenable_strobes c=%0d: got %b want %b", c,
                         st, {(c % HT) < HA, (c % HT) == HT - 1, 1'b0});
            end
            pin   = {dif.vga_r, dif.vga_g, dif.vga_b,
                     dif.vga_hsync, dif.vga_vsync};
            pin_e = (c < 3) ? {12'h000, 2'b11} : exp_pins(c - 3, 12'hF0A);
            n_cmp++;
            if (pin !== pin_e) begin
                n_bad++;
                $display("FAIL reenable_pins c=%0d: got %h want %h",
                         c, pin, pin_e);
            end
        end
    endtask

    task automatic test_midreset();
        logic [17:0] got;
        logic [3:0]  st;
        logic [3:0]  st_e;
        while (k < FT + 12 * HT + 40) tick();
        rst_n = 1'b0;
        @(negedge clk);
        got = {dif.display_next_pixel, dif.display_next_line,
               dif.display_next_frame, dif.display_current_field,
               dif.vga_r, dif.vga_g, dif.vga_b,
               dif.vga_hsync, dif.vga_vsync};
        n_cmp++;
        if (got !== {4'b0000, 12'h000, 2'b11}) begin
            n_bad++;
            $display("FAIL midreset_state: got %h want %h", got,
                     {4'b0000, 12'h000, 2'b11});
        end
        rst_n = 1'b1;
        for (int c = 0; c < FT + HT; c++) begin
            @(negedge clk);
            k    = c;
            st   = {dif.display_next_pixel, dif.display_next_line,
                    dif.display_next_frame, dif.display_current_field};
            st_e = {(c % HT) < HA, (c % HT) == HT - 1,
                    (c % FT) == FT - 1, exp_field(c)};
            n_cmp++;
            if (st !== st_e) begin
                n_bad++;
                $display("FAIL post_reset c=%0d: got %b want %b",
                         c, st, st_e);
            end
        end
    endtask

    initial begin
        dif.video_enable = 1'b0;
        dif.rgb_in = 12'hF0A;
        test_reset();
        test_line();
        test_frame();
        test_colour();
        test_enable();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
